// File: rtl/acc_drain_arbiter_if.sv
// ============================================================================
// acc_drain_arbiter_if : request/result bus between drain sources and arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface acc_drain_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*18-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  out_valid;
   logic                  out_ready;
   logic [15:0]           out_bf16;
   logic [ID_W-1:0]       out_id;
   logic                  busy;

   // master: drain sources plus downstream sink; slave: the arbiter itself
   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_bf16, out_id, busy
   );
   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_bf16, out_id, busy
   );
endinterface

`default_nettype wire

// File: rtl/acc_drain_arbiter.sv
// ============================================================================
// acc_drain_arbiter : round-robin share of one int18->bf16 converter, 2-stage
// pipeline. Optional perf/stall counters with ACC_DRAIN_PERF_CNT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module int18_to_bf16_lzd #(
   parameter int FRAC_BITS = 8
) (
   input  wire logic [17:0] acc,
   output logic      [15:0] bf16
);
   logic [17:0] mag;
   logic [17:0] norm;
   logic [4:0]  lead;
   logic [7:0]  exp_f;
   logic [6:0]  mant;

   always_comb begin
      mag  = acc[17] ? (~acc + 18'd1) : acc;
      lead = '0;
      for (int i = 0; i < 18; i++) begin
         if (mag[i]) lead = 5'(i);
      end
      // leading one moved to bit 17; the 7 bits below it are kept, rest truncated
      norm  = mag << (5'd17 - lead);
      mant  = 7'(norm >> 10);
      exp_f = 8'(int'(lead) + 127 - FRAC_BITS);
      bf16  = (mag == '0) ? 16'h0000 : {acc[17], exp_f, mant};
   end
endmodule

module acc_drain_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int FRAC_BITS = 8,
   parameter int ID_W      = 2
) (
   input  wire logic             clk,
   input  wire logic             rst,
   acc_drain_arbiter_if.slave    bus
`ifdef ACC_DRAIN_PERF_CNT_EN
   ,
   output logic [15:0]           perf_cnt,
   output logic [15:0]           stall_cnt
`endif
);
   logic              s0_v_q, s0_v_d;
   logic [17:0]       s0_acc_q, s0_acc_d;
   logic [ID_W-1:0]   s0_id_q, s0_id_d;
   logic              s1_v_q, s1_v_d;
   logic [15:0]       out_bf16_q, out_bf16_d;
   logic [ID_W-1:0]   out_id_q, out_id_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic              s0_adv, s1_adv;
   logic              found;
   logic [ID_W-1:0]   g;
   logic [NUM_REQ-1:0] grant;
   logic              transfer;
   logic [15:0]       conv_bf16;

   int18_to_bf16_lzd #(.FRAC_BITS(FRAC_BITS)) u_conv (
      .acc  (s0_acc_q),
      .bf16 (conv_bf16)
   );

   assign s1_adv   = !s1_v_q | bus.out_ready;
   assign s0_adv   = !s0_v_q | s1_adv;
   assign transfer = found & s0_adv;

   // descending scan so the source closest after rr_ptr wins
   always_comb begin
      int idx;
      found = 1'b0;
      g     = '0;
      idx   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (bus.req_valid[ID_W'(idx)]) begin
            found = 1'b1;
            g     = ID_W'(idx);
         end
      end
      grant = found ? (NUM_REQ'(1) << g) : '0;
   end

   always_comb begin
      s0_v_d     = s0_v_q;
      s0_acc_d   = s0_acc_q;
      s0_id_d    = s0_id_q;
      s1_v_d     = s1_v_q;
      out_bf16_d = out_bf16_q;
      out_id_d   = out_id_q;
      rr_ptr_d   = rr_ptr_q;
      if (s0_adv) begin
         s0_v_d   = found;
         s0_acc_d = bus.req_data[int'(g)*18 +: 18];
         s0_id_d  = g;
      end
      if (s1_adv) begin
         s1_v_d     = s0_v_q;
         out_bf16_d = conv_bf16;
         out_id_d   = s0_id_q;
      end
      if (transfer) begin
         rr_ptr_d = (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_v_q     <= 1'b0;
         s0_acc_q   <= '0;
         s0_id_q    <= '0;
         s1_v_q     <= 1'b0;
         out_bf16_q <= '0;
         out_id_q   <= '0;
         rr_ptr_q   <= '0;
      end else begin
         s0_v_q     <= s0_v_d;
         s0_acc_q   <= s0_acc_d;
         s0_id_q    <= s0_id_d;
         s1_v_q     <= s1_v_d;
         out_bf16_q <= out_bf16_d;
         out_id_q   <= out_id_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   // grants are suppressed while reset is held so no source sees a phantom accept
   assign bus.req_ready = rst ? '0 : (grant & {NUM_REQ{s0_adv}});
   assign bus.out_valid = s1_v_q;
   assign bus.out_bf16  = out_bf16_q;
   assign bus.out_id    = out_id_q;
   assign bus.busy      = s0_v_q | s1_v_q;

`ifdef ACC_DRAIN_PERF_CNT_EN
   logic [15:0] perf_cnt_q, perf_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      perf_cnt_d  = perf_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (s1_v_q & bus.out_ready & (perf_cnt_q != 16'hFFFF))
         perf_cnt_d = perf_cnt_q + 16'd1;
      if (s1_v_q & !bus.out_ready & (stall_cnt_q != 16'hFFFF))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         perf_cnt_q  <= perf_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_cnt  = perf_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
`endif
endmodule

`default_nettype wire

// File: tb/tb_acc_drain_arbiter.sv
// ============================================================================
// tb_acc_drain_arbiter : randomized bench against a queue-based reference
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_acc_drain_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int ID_W      = 2;
   localparam int FRAC_BITS = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   acc_drain_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

`ifdef ACC_DRAIN_PERF_CNT_EN
   logic [15:0] perf_cnt, stall_cnt;
`endif

   acc_drain_arbiter #(.NUM_REQ(NUM_REQ), .FRAC_BITS(FRAC_BITS), .ID_W(ID_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef ACC_DRAIN_PERF_CNT_EN
      ,
      .perf_cnt  (perf_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   typedef struct {
      int          id;
      logic [15:0] bf;
      int          stamp;
   } item_t;

   item_t q[$];
   int    rr_m;
   int    cyc;
   int    hs_m, st_m;
   int    n_chk, n_fail;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // value = acc / 2^FRAC_BITS, normalised by repeated doubling, mantissa truncated
   function automatic logic [15:0] bf16_ref(input logic signed [17:0] a);
      int mag, sh, e, m, s;
      if (a == 0) return 16'h0000;
      s   = (a < 0) ? 1 : 0;
      mag = (a < 0) ? -int'(a) : int'(a);
      sh  = 0;
      while (mag < (1 << 17)) begin
         mag = mag * 2;
         sh++;
      end
      e = 17 - sh - FRAC_BITS + 127;
      m = (mag >> 10) & 127;
      return 16'((s << 15) | ((e & 255) << 7) | m);
   endfunction

   function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
      for (int k = 0; k < NUM_REQ; k++) begin
         int i;
         i = (ptr + k) % NUM_REQ;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [NUM_REQ*18-1:0] rand_data();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[NUM_REQ*18-1:0];
   endfunction

   task automatic step(input logic [NUM_REQ-1:0] v, input logic ordy,
                       input logic [NUM_REQ*18-1:0] d);
      logic exp_ov, acc_ok;
      int   g;
      logic [NUM_REQ-1:0] exp_rdy;
      @(negedge clk);
      bus.req_valid = v;
      bus.req_data  = d;
      bus.out_ready = ordy;
      #1;
      exp_ov = (q.size() >= 2) || (q.size() == 1 && q[0].stamp < cyc - 1);
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("busy", 32'(bus.busy), 32'(q.size() > 0));
      if (exp_ov) begin
         chk("out_bf16", 32'(bus.out_bf16), 32'(q[0].bf));
         chk("out_id", 32'(bus.out_id), 32'(q[0].id));
      end
      acc_ok  = (q.size() < 2) || ordy;
      g       = pick(v, rr_m);
      exp_rdy = (acc_ok && g >= 0) ? NUM_REQ'(1 << g) : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
`ifdef ACC_DRAIN_PERF_CNT_EN
      chk("perf_cnt", 32'(perf_cnt), 32'(hs_m));
      chk("stall_cnt", 32'(stall_cnt), 32'(st_m));
`endif
      if (exp_ov && ordy && hs_m < 65535) hs_m++;
      if (exp_ov && !ordy && st_m < 65535) st_m++;
      if (exp_ov && ordy) void'(q.pop_front());
      if (acc_ok && g >= 0) begin
         item_t it;
         it.id    = g;
         it.bf    = bf16_ref(d[g*18 +: 18]);
         it.stamp = cyc;
         q.push_back(it);
         rr_m = (g + 1) % NUM_REQ;
      end
      cyc++;
   endtask

   task automatic drain();
      for (int i = 0; i < 6; i++) step('0, 1'b1, rand_data());
   endtask

   // single value on source 0; result visible on the third step
   task automatic conv_one(input logic [17:0] val, input logic [15:0] lit);
      logic [NUM_REQ*18-1:0] d;
      drain();
      d = rand_data();
      d[17:0] = val;
      step(4'b0001, 1'b1, d);
      step('0, 1'b1, rand_data());
      step('0, 1'b1, rand_data());
      chk("conv_literal", 32'(bus.out_bf16), 32'(lit));
      chk("conv_id", 32'(bus.out_id), 32'd0);
   endtask

   initial begin
      logic [NUM_REQ*18-1:0] d;
      n_chk = 0; n_fail = 0; cyc = 0; rr_m = 0; hs_m = 0; st_m = 0;
      bus.req_valid = '1;
      bus.req_data  = rand_data();
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_out_bf16", 32'(bus.out_bf16), 32'd0);
      chk("rst_out_id", 32'(bus.out_id), 32'd0);
      bus.req_valid = '0;
      rst = 1'b0;

      conv_one(18'd256, 16'h3F80);
      conv_one(18'h3FF00, 16'hBF80);
      conv_one(18'd384, 16'h3FC0);
      conv_one(18'd1, 16'h3B80);
      conv_one(18'd0, 16'h0000);
      drain();

      // all sources valid, full throughput
      for (int i = 0; i < 20; i++) step('1, 1'b1, rand_data());
      // backpressure then release
      for (int i = 0; i < 5; i++) step('1, 1'b0, rand_data());
      for (int i = 0; i < 10; i++) step('1, 1'b1, rand_data());
      drain();

      // rr_ptr at 2 with only sources 0 and 3 requesting
      step(4'b0010, 1'b1, rand_data());
      for (int i = 0; i < 4; i++) step(4'b1001, 1'b1, rand_data());
      drain();

      // randomized traffic with varying density and backpressure
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < 400; i++) begin
            logic [NUM_REQ-1:0] v;
            logic r;
            v = NUM_REQ'($urandom());
            if (ph == 0) v = v & NUM_REQ'($urandom());
            r = ($urandom_range(0, 3) >= ph % 3);
            step(v, r, rand_data());
         end
      end

      // reset with both stages full
      for (int i = 0; i < 6; i++) step('1, 1'b0, rand_data());
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
`ifdef ACC_DRAIN_PERF_CNT_EN
      chk("midrst_perf_cnt", 32'(perf_cnt), 32'd0);
      chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      q.delete();
      rr_m = 0; hs_m = 0; st_m = 0;
      bus.req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      d = rand_data();
      step('1, 1'b1, d);
      chk("post_rst_grant", 32'(bus.req_ready), 32'd1);
      for (int i = 0; i < 12; i++) step('1, 1'b1, rand_data());
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
